// File: rtl/fpcvt_pkg.sv
// Shared constants, float-word field positions and FSM state type for the
// linear<->float converter pair.
package fpcvt_pkg;

  localparam int EXP_W  = 3;
  localparam int SIG_W  = 4;
  localparam int LIN_W  = 12;
  localparam int WORD_W = 1 + EXP_W + SIG_W;

  // Float word layout: {sign, exponent, significand}
  localparam int SIGN_BIT = WORD_W - 1;
  localparam int EXP_HI   = WORD_W - 2;
  localparam int EXP_LO   = SIG_W;
  localparam int SIG_HI   = SIG_W - 1;
  localparam int SIG_LO   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp_expand_sm_to_tc.sv
// Sign-magnitude to two's-complement restore; a zero magnitude stays zero
// whatever the sign, so no negative zero can escape.
module sm_to_tc #(
  parameter int W = 12
) (
  input  logic         sgn,
  input  logic [W-2:0] mag,
  output logic [W-1:0] tc
);

  logic [W-1:0] ext;

  always_comb begin
    ext = {1'b0, mag};
    tc  = sgn ? (~ext + 1'b1) : ext;
  end

endmodule

// File: rtl/fp_expand.sv
// Iterative float-to-linear expander: one left shift per cycle, valid/ready
// on both sides, single output buffer.
module fp_expand #(
  parameter int EXP_W = fpcvt_pkg::EXP_W,
  parameter int SIG_W = fpcvt_pkg::SIG_W,
  parameter int LIN_W = fpcvt_pkg::LIN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+SIG_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LIN_W-1:0]       out_data
);

  import fpcvt_pkg::state_t;
  import fpcvt_pkg::IDLE;
  import fpcvt_pkg::SHIFT;
  import fpcvt_pkg::DONE;

  localparam int ACC_W = LIN_W - 1;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [EXP_W-1:0]   cnt;
  logic               sgn;
  logic [LIN_W-1:0]   res_tc;

  logic               w_sgn;
  logic [EXP_W-1:0]   w_exp;
  logic [SIG_W-1:0]   w_sig;

  assign w_sgn = in_data[EXP_W+SIG_W];
  assign w_exp = in_data[EXP_W+SIG_W-1:SIG_W];
  assign w_sig = in_data[SIG_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)     state_nxt = SHIFT;
      SHIFT:   if (cnt == '0)    state_nxt = DONE;
      DONE:    if (out_ready)    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes: no out_ready -> in_ready path.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  sm_to_tc #(.W(LIN_W)) u_sm_to_tc (
    .sgn (sgn),
    .mag (acc),
    .tc  (res_tc)
  );

  // Datapath: magnitude shifter, exponent countdown, result buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      sgn      <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc <= {{(ACC_W-SIG_W){1'b0}}, w_sig};
          cnt <= w_exp;
          sgn <= w_sgn;
        end
        SHIFT: begin
          if (cnt != '0) begin
            acc <= acc << 1;
            cnt <= cnt - 1'b1;
          end else begin
            out_data <= res_tc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
